// File: rtl/vip_frame_source.sv
// Synthetic video source: full frames with programmable geometry, pixel-slot divider
// and four test patterns, in the per_frame_* stream format of the VIP detector chain.
module vip_frame_source #(
  parameter int H_ACTIVE  = 640,
  parameter int H_BLANK   = 160,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int V_ACTIVE  = 480,
  parameter int V_FRONT   = 10,
  parameter int CLKEN_DIV = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  output logic       per_frame_vsync,
  output logic       per_frame_href,
  output logic       per_frame_clken,
  output logic [7:0] per_img_Y,
  output logic       frame_done,
  output logic       busy
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  localparam logic [3:0]  DIV_LAST    = 4'(CLKEN_DIV - 1);
  localparam logic [12:0] X_LAST      = 13'(H_TOTAL - 1);
  localparam logic [12:0] X_ACT       = 13'(H_ACTIVE);
  localparam logic [15:0] Y_SYNC_LAST = 16'(V_SYNC - 1);
  localparam logic [15:0] Y_BACK_LAST = 16'(V_SYNC + V_BACK - 1);
  localparam logic [15:0] Y_ACT_LAST  = 16'(V_SYNC + V_BACK + V_ACTIVE - 1);
  localparam logic [15:0] Y_LAST      = 16'(V_TOTAL - 1);
  localparam logic [15:0] Y_ACT0      = 16'(V_SYNC + V_BACK);

  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

  state_t      state, state_next;
  logic [3:0]  div;
  logic [12:0] x;
  logic [15:0] y;
  logic [1:0]  pat;
  logic        start;
  logic        tick, slot_end, line_end, frame_end;
  logic        active_px, ay_b4;

  function automatic logic [7:0] pattern_value(input logic [1:0] p, input logic [7:0] ax,
                                               input logic ay_bit4);
    case (p)
      2'd0:    pattern_value = ax;
      2'd1:    pattern_value = ax[5] ? 8'hFF : 8'h00;
      2'd2:    pattern_value = (ax[4] ^ ay_bit4) ? 8'hFF : 8'h00;
      default: pattern_value = 8'h80;
    endcase
  endfunction

  // tick opens a pixel slot (clken point); counters move when the slot closes
  assign tick      = (div == 4'd0);
  assign slot_end  = (div == DIV_LAST);
  assign line_end  = slot_end && (x == X_LAST);
  assign frame_end = line_end && (y == Y_LAST);
  assign active_px = (state == ACTIVE) && (x < X_ACT);
  assign ay_b4     = 1'((y - Y_ACT0) >> 4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_next = VSYNC;
          start      = 1'b1;
        end
      end
      VSYNC:  if (line_end && y == Y_SYNC_LAST) state_next = VBACK;
      VBACK:  if (line_end && y == Y_BACK_LAST) state_next = ACTIVE;
      ACTIVE: if (line_end && y == Y_ACT_LAST)  state_next = VFRONT;
      VFRONT: begin
        if (frame_end) begin
          if (enable) begin
            state_next = VSYNC;
            start      = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      x   <= '0;
      y   <= '0;
      pat <= '0;
    end else if (start) begin
      div <= '0;
      x   <= '0;
      y   <= '0;
      pat <= pattern_sel;
    end else if (state != IDLE) begin
      div <= slot_end ? 4'd0 : div + 4'd1;
      if (slot_end) begin
        if (x == X_LAST) begin
          x <= '0;
          y <= frame_end ? 16'd0 : y + 16'd1;
        end else begin
          x <= x + 13'd1;
        end
      end
    end
  end

  // Output register stage: everything lags the counters/state by one clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_frame_vsync <= 1'b0;
      per_frame_href  <= 1'b0;
      per_frame_clken <= 1'b0;
      per_img_Y       <= 8'h00;
      frame_done      <= 1'b0;
      busy            <= 1'b0;
    end else begin
      per_frame_vsync <= (state == VSYNC);
      per_frame_href  <= active_px;
      per_frame_clken <= active_px && tick;
      frame_done      <= (state == VFRONT) && frame_end;
      busy            <= (state != IDLE);
      if (tick) per_img_Y <= active_px ? pattern_value(pat, x[7:0], ay_b4) : 8'h00;
    end
  end

endmodule
